// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: loads a 16-word block and streams W[0..63] with K[t].
// Optional feature: define SHA256_SCHED_ABORT_EN to add the abort_i input.
module sha256_msg_sched (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] word_i,
    input  logic        word_valid_i,
    output logic        word_ready_o,
    output logic [31:0] w_o,
    output logic [31:0] k_o,
    output logic [5:0]  round_o,
    output logic        w_valid_o,
    input  logic        w_ready_i,
    output logic        last_o
`ifdef SHA256_SCHED_ABORT_EN
    ,
    input  logic        abort_i
`endif
);
    localparam logic LOAD = 1'b0;
    localparam logic RUN  = 1'b1;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic        state_q, state_d;
    logic [3:0]  lcnt_q, lcnt_d;
    logic [5:0]  rnd_q, rnd_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic        word_hs, rnd_hs, abort;
    logic [31:0] w_new;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

`ifdef SHA256_SCHED_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    assign word_hs = word_valid_i & (state_q == LOAD);
    assign rnd_hs  = w_ready_i & (state_q == RUN);
    assign w_new   = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

    // State, counters and window registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= LOAD;
            lcnt_q  <= '0;
            rnd_q   <= '0;
            win_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
            rnd_q   <= rnd_d;
            win_q   <= win_d;
        end
    end

    // Next state: LOAD -> RUN after 16th word, RUN -> LOAD after round 63
    always_comb begin
        state_d = state_q;
        if (word_hs && lcnt_q == 4'd15) state_d = RUN;
        if (rnd_hs && rnd_q == 6'd63) state_d = LOAD;
        if (abort) state_d = LOAD;
    end

    // Window shift and counter advance; abort clears everything and drops the handshake
    always_comb begin
        win_d  = win_q;
        lcnt_d = lcnt_q;
        rnd_d  = rnd_q;
        if (word_hs || rnd_hs) begin
            for (int j = 0; j < 15; j++) win_d[j] = win_q[j+1];
            win_d[15] = word_hs ? word_i : w_new;
        end
        if (word_hs) lcnt_d = lcnt_q + 4'd1;
        if (rnd_hs) rnd_d = rnd_q + 6'd1;
        if (rnd_hs && rnd_q == 6'd63) lcnt_d = '0;
        if (abort) begin
            win_d  = '{default: '0};
            lcnt_d = '0;
            rnd_d  = '0;
        end
    end

    // Outputs come straight from registers or the ROM indexed by rnd_q
    always_comb begin
        word_ready_o = (state_q == LOAD);
        w_valid_o    = (state_q == RUN);
        w_o          = win_q[0];
        k_o          = K[rnd_q];
        round_o      = rnd_q;
        last_o       = (state_q == RUN) && (rnd_q == 6'd63);
    end
endmodule
